// File: rtl/cpu_sequencer.sv
// Multi-cycle execution controller for MiniRISC: FETCH/DECODE/(MEM)/EXECUTE with
// run/step/halt control and saturating counters. Define SEQ_BREAKPOINT_EN for the PC breakpoint.
module cpu_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Run,
  input  logic             i_Step,
  input  logic             i_Halt,
  input  logic             i_RegWrite_En,
  input  logic             i_MemWrite_En,
  input  logic             i_UseMem,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [4:0]       i_PC,
  input  logic [4:0]       i_Break_Addr,
  input  logic             i_Break_Valid,
  output logic             o_Break_Hit,
`endif
  output logic             o_Ir_Load,
  output logic             o_PC_En,
  output logic             o_Reg_We,
  output logic             o_Mem_We,
  output logic [2:0]       o_State,
  output logic             o_Halted,
  output logic [CNT_W-1:0] o_Cycle_Count,
  output logic [CNT_W-1:0] o_Inst_Count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_MEM     = 3'd3,
    S_EXECUTE = 3'd4,
    S_HALTED  = 3'd5
  } state_e;

  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;
  localparam bit HAS_MEM = (MEM_LAT > 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cyc_q, inst_q;
  logic                inst_inc;
  logic                active;
  logic                ir_load, pc_en, reg_we, mem_we;
`ifdef SEQ_BREAKPOINT_EN
  logic                bypass_q, bypass_d;
  logic                break_hit;
`endif

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    wait_d   = wait_q;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    inst_inc = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bypass_d  = bypass_q;
    break_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_Run) begin
          step_d = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
          // Pause once on the armed address; the bypass lets the retry through.
          if (i_Break_Valid && (i_PC == i_Break_Addr) && !bypass_q) begin
            break_hit = 1'b1;
            bypass_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
`else
          state_d = S_FETCH;
`endif
        end else if (i_Step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (HAS_MEM && i_UseMem && !i_MemWrite_En) begin
          state_d = S_MEM;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_MEM: begin
        if (wait_q == '0) state_d = S_EXECUTE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_EXECUTE: begin
        inst_inc = 1'b1;
        step_d   = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
        bypass_d = 1'b0;
`endif
        if (i_Halt) begin
          state_d = S_HALTED;
        end else begin
          pc_en  = 1'b1;
          reg_we = i_RegWrite_En;
          mem_we = i_MemWrite_En;
          state_d = (step_q || !i_Run) ? S_IDLE : S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active = (state_q != S_IDLE) && (state_q != S_HALTED);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cyc_q   <= active   ? sat_inc(cyc_q)  : cyc_q;
      inst_q  <= inst_inc ? sat_inc(inst_q) : inst_q;
    end
  end

  // The wait counter is always loaded before it is read, so it needs no reset.
  always_ff @(posedge i_Clk) begin
    wait_q <= wait_d;
  end

`ifdef SEQ_BREAKPOINT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) bypass_q <= 1'b0;
    else       bypass_q <= bypass_d;
  end

  assign o_Break_Hit = break_hit & ~i_Rst;
`endif

  assign o_Ir_Load     = ir_load & ~i_Rst;
  assign o_PC_En       = pc_en   & ~i_Rst;
  assign o_Reg_We      = reg_we  & ~i_Rst;
  assign o_Mem_We      = mem_we  & ~i_Rst;
  assign o_State       = state_q;
  assign o_Halted      = (state_q == S_HALTED);
  assign o_Cycle_Count = cyc_q;
  assign o_Inst_Count  = inst_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: instructions are issued at FETCH, expected
// write strobes and latency are queued and retired against each PC strobe.
module tb_cpu_sequencer;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;

  logic i_Clk = 1'b0;
  logic i_Rst, i_Run, i_Step, i_Halt, i_RegWrite_En, i_MemWrite_En, i_UseMem;
  logic o_Ir_Load, o_PC_En, o_Reg_We, o_Mem_We, o_Halted;
  logic [2:0] o_State;
  logic [CNT_W-1:0] o_Cycle_Count, o_Inst_Count;
`ifdef SEQ_BREAKPOINT_EN
  logic [4:0] i_PC, i_Break_Addr;
  logic i_Break_Valid, o_Break_Hit;
`endif

  cpu_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Run(i_Run), .i_Step(i_Step), .i_Halt(i_Halt),
    .i_RegWrite_En(i_RegWrite_En), .i_MemWrite_En(i_MemWrite_En), .i_UseMem(i_UseMem),
`ifdef SEQ_BREAKPOINT_EN
    .i_PC(i_PC), .i_Break_Addr(i_Break_Addr), .i_Break_Valid(i_Break_Valid),
    .o_Break_Hit(o_Break_Hit),
`endif
    .o_Ir_Load(o_Ir_Load), .o_PC_En(o_PC_En), .o_Reg_We(o_Reg_We), .o_Mem_We(o_Mem_We),
    .o_State(o_State), .o_Halted(o_Halted),
    .o_Cycle_Count(o_Cycle_Count), .o_Inst_Count(o_Inst_Count)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct { bit use_mem; bit reg_we; bit mem_we; bit halt; } instr_t;
  typedef struct { bit reg_we; bit mem_we; int lat; } exp_t;

  instr_t prog[$];
  exp_t   sb[$];
  int     trace[$];
  int     pi, total, bad, ncyc, fetch_t, pc_cnt, ld_cnt;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic instr_t mk(input bit u, input bit r, input bit m, input bit h);
    instr_t t;
    t.use_mem = u; t.reg_we = r; t.mem_we = m; t.halt = h;
    return t;
  endfunction

  // One clock: sample at the falling edge, retire PC strobes, then issue at FETCH.
  task automatic cyc();
    exp_t e;
    instr_t p;
    @(negedge i_Clk);
    ncyc++;
    if (o_Ir_Load) begin
      fetch_t = ncyc;
      ld_cnt++;
    end
    if (o_Reg_We || o_Mem_We) chk("we_state", int'(o_State), 4);
    if (o_PC_En) begin
      pc_cnt++;
`ifdef SEQ_BREAKPOINT_EN
      i_PC = i_PC + 5'd1;
`endif
      if (sb.size() == 0) chk("pc_en_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("reg_we", int'(o_Reg_We), int'(e.reg_we));
        chk("mem_we", int'(o_Mem_We), int'(e.mem_we));
        chk("latency", ncyc - fetch_t + 1, e.lat);
      end
    end
    if (o_State != 3'd0 && o_State != 3'd5) trace.push_back(int'(o_State));
    if (o_Ir_Load && pi < prog.size()) begin
      p = prog[pi];
      i_UseMem = p.use_mem; i_RegWrite_En = p.reg_we;
      i_MemWrite_En = p.mem_we; i_Halt = p.halt;
      if (!p.halt) begin
        e.reg_we = p.reg_we; e.mem_we = p.mem_we;
        e.lat = (p.use_mem && !p.mem_we) ? 3 + MEM_LAT : 3;
        sb.push_back(e);
      end
      pi++;
      if (pi == prog.size()) i_Run = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound; k++) begin
      cyc();
      if (pi == prog.size() && o_State == 3'd0) return;
    end
    chk("timeout_idle", 0, 1);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1; i_Run = 1'b0; i_Step = 1'b0; i_Halt = 1'b0;
    i_RegWrite_En = 1'b0; i_MemWrite_En = 1'b0; i_UseMem = 1'b0;
    cyc();
    cyc();
    i_Rst = 1'b0;
    prog.delete(); sb.delete(); trace.delete();
    pi = 0; pc_cnt = 0; ld_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_tr[8];
    int cc0, l0, p0;
    bit sent;
    total = 0; bad = 0; ncyc = 0; fetch_t = 0;
`ifdef SEQ_BREAKPOINT_EN
    i_PC = 5'd0; i_Break_Addr = 5'd0; i_Break_Valid = 1'b0;
`endif
    do_reset();
    #1;
    chk("rst_state", int'(o_State), 0);
    chk("rst_cyc", int'(o_Cycle_Count), 0);
    chk("rst_inst", int'(o_Inst_Count), 0);
    chk("rst_halted", int'(o_Halted), 0);
    chk("rst_strobes", int'({o_Ir_Load, o_PC_En, o_Reg_We, o_Mem_We}), 0);

    // Four ALU instructions in free-run.
    for (int k = 0; k < 4; k++) prog.push_back(mk(0, 1, 0, 0));
    i_Run = 1'b1;
    wait_done(40);
    chk("alu_inst", int'(o_Inst_Count), 4);
    chk("alu_cyc", int'(o_Cycle_Count), 12);
    chk("alu_pc_cnt", pc_cnt, 4);
    chk("alu_active", trace.size(), 12);
    chk("alu_sb_empty", sb.size(), 0);

    // Load then store.
    do_reset();
    prog.push_back(mk(1, 1, 0, 0));
    prog.push_back(mk(1, 0, 1, 0));
    i_Run = 1'b1;
    wait_done(40);
    exp_tr = '{1, 2, 3, 3, 4, 1, 2, 4};
    chk("ls_trace_len", trace.size(), 8);
    if (trace.size() == 8)
      for (int k = 0; k < 8; k++) chk("ls_trace", trace[k], exp_tr[k]);
    chk("ls_inst", int'(o_Inst_Count), 2);
    chk("ls_cyc", int'(o_Cycle_Count), 8);

    // Single step, with a second step pulse during DECODE.
    do_reset();
    prog.push_back(mk(0, 1, 0, 0));
    i_Step = 1'b1;
    cyc();
    i_Step = 1'b0;
    sent = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (o_State == 3'd2 && !sent) begin
        i_Step = 1'b1;
        sent = 1'b1;
      end else begin
        i_Step = 1'b0;
      end
      if (pi == prog.size() && o_State == 3'd0) break;
    end
    repeat (6) cyc();
    chk("step_state", int'(o_State), 0);
    chk("step_inst", int'(o_Inst_Count), 1);
    chk("step_pc_cnt", pc_cnt, 1);
    chk("step_fetches", ld_cnt, 1);

    // Halt: ALU then HALT, then run/step held while halted.
    do_reset();
    prog.push_back(mk(0, 1, 0, 0));
    prog.push_back(mk(0, 1, 1, 1));
    i_Run = 1'b1;
    for (int k = 0; k < 30 && !o_Halted; k++) cyc();
    chk("halt_flag", int'(o_Halted), 1);
    chk("halt_state", int'(o_State), 5);
    chk("halt_inst", int'(o_Inst_Count), 2);
    chk("halt_pc_cnt", pc_cnt, 1);
    chk("halt_cyc", int'(o_Cycle_Count), 6);
    cc0 = int'(o_Cycle_Count); l0 = ld_cnt; p0 = pc_cnt;
    i_Run = 1'b1; i_Step = 1'b1;
    repeat (20) cyc();
    chk("halted_fetch", ld_cnt - l0, 0);
    chk("halted_pc", pc_cnt - p0, 0);
    chk("halted_state", int'(o_State), 5);
    chk("halted_cyc", int'(o_Cycle_Count), cc0);
    do_reset();
    #1;
    chk("unhalt_state", int'(o_State), 0);
    chk("unhalt_inst", int'(o_Inst_Count), 0);
    chk("unhalt_cyc", int'(o_Cycle_Count), 0);

    // Reset arriving during EXECUTE of a store.
    prog.push_back(mk(0, 0, 1, 0));
    i_Run = 1'b1;
    for (int k = 0; k < 20 && o_State != 3'd2; k++) cyc();
    @(posedge i_Clk);
    #1;
    chk("rx_state", int'(o_State), 4);
    chk("rx_mem_we_pre", int'(o_Mem_We), 1);
    i_Rst = 1'b1;
    #1;
    chk("rx_mem_we", int'(o_Mem_We), 0);
    chk("rx_pc_en", int'(o_PC_En), 0);
    @(posedge i_Clk);
    #1;
    chk("rx_state_after", int'(o_State), 0);
    do_reset();

    // Counter saturation over twenty instructions.
    for (int k = 0; k < 20; k++) prog.push_back(mk(0, 1, 0, 0));
    i_Run = 1'b1;
    wait_done(200);
    chk("sat_inst", int'(o_Inst_Count), 15);
    chk("sat_cyc", int'(o_Cycle_Count), 15);
    chk("sat_pc_cnt", pc_cnt, 20);

`ifdef SEQ_BREAKPOINT_EN
    do_reset();
    i_PC = 5'd3; i_Break_Addr = 5'd3; i_Break_Valid = 1'b1;
    prog.push_back(mk(0, 1, 0, 0));
    i_Run = 1'b1;
    #1;
    chk("bp_hit", int'(o_Break_Hit), 1);
    cyc();
    chk("bp_paused", int'(o_State), 0);
    chk("bp_hit_once", int'(o_Break_Hit), 0);
    i_Run = 1'b0;
    cyc();
    i_Run = 1'b1;
    wait_done(30);
    chk("bp_pc_cnt", pc_cnt, 1);
    chk("bp_pc", int'(i_PC), 4);
    i_Break_Valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle execution controller for the MiniRISC core.
- Steps each instruction through FETCH/DECODE/(MEM)/EXECUTE and gates PC advance, register-file write and RAM write so each fires once per instruction.
- Adds run/single-step/halt control plus cycle and retired-instruction counters.
- Sits between the control unit's raw enables and the PC, register file and RAM.

Parameters:
- MEM_LAT, 1, extra wait cycles for a RAM read (load) before EXECUTE; 0 skips the MEM state.
- CNT_W, 16, width of the cycle and instruction counters.

Ports:
- i_Clk  in  1  core clock
- i_Rst  in  1  synchronous, active-high reset
- i_Run  in  1  level; 1 = free-run, 0 = stop after the current instruction
- i_Step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
- i_Halt  in  1  control unit: current instruction is HALT
- i_RegWrite_En  in  1  raw register-write request from control
- i_MemWrite_En  in  1  raw RAM-write request from control
- i_UseMem  in  1  control: instruction reads RAM (load)
- o_Ir_Load  out  1  latch ROM output into the instruction register
- o_PC_En  out  1  PC update strobe (PC takes jump or +1)
- o_Reg_We  out  1  gated register-file write enable
- o_Mem_We  out  1  gated RAM write enable
- o_State  out  3  current state encoding
- o_Halted  out  1  core is in HALTED
- o_Cycle_Count  out  CNT_W  active cycles
- o_Inst_Count  out  CNT_W  retired instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, EXECUTE=4, HALTED=5. Codes 6 and 7 recover to IDLE on the next edge.
- Reset (i_Rst=1 at edge): state=IDLE, step flag=0, both counters=0.
  - While i_Rst=1, o_Ir_Load, o_PC_En, o_Reg_We and o_Mem_We are forced to 0 combinationally, including mid-instruction.
- All strobes are combinational decodes of the registered state. Each strobe is high for exactly one cycle per instruction.
- IDLE:
  - i_Run=1 -> FETCH.
  - else i_Step=1 -> FETCH with step flag=1.
  - If both are high, treat as run; step flag stays 0.
- FETCH: o_Ir_Load=1 -> DECODE.
- DECODE: no strobes.
  - If i_UseMem=1 and i_MemWrite_En=0 and MEM_LAT>0 -> MEM, with wait counter loaded to MEM_LAT-1.
  - else -> EXECUTE.
- MEM: wait counter decrements each cycle; -> EXECUTE in the cycle the counter reads 0.
- EXECUTE, i_Halt=1:
  - o_PC_En=0, o_Reg_We=0, o_Mem_We=0.
  - Instruction count increments.
  - -> HALTED.
- EXECUTE, i_Halt=0:
  - o_PC_En=1, o_Reg_We=i_RegWrite_En, o_Mem_We=i_MemWrite_En.
  - Instruction count increments.
  - Step flag=1 or i_Run=0 -> IDLE, step flag cleared; else -> FETCH.
- HALTED: o_Halted=1, all strobes 0. i_Run and i_Step are ignored; only i_Rst exits.
- Latency: 3 cycles per non-load instruction; 3+MEM_LAT cycles per load.
- Cycle counter: +1 in every cycle whose state is not IDLE or HALTED.
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- i_Step outside IDLE is ignored and not queued.
- i_Run falling mid-instruction: the instruction completes, then IDLE.

Optional Feature:
- Macro: SEQ_BREAKPOINT_EN.
- When defined, adds these ports:
  - i_PC  in  5  current PC
  - i_Break_Addr  in  5  breakpoint address
  - i_Break_Valid  in  1  breakpoint armed
  - o_Break_Hit  out  1  breakpoint hit pulse
- In IDLE with i_Run=1: if i_Break_Valid=1, i_PC==i_Break_Addr and the bypass bit is clear:
  - stay in IDLE;
  - pulse o_Break_Hit for one cycle;
  - set the bypass bit.
- The bypass bit lets the next run or step execute that address. It clears after the next EXECUTE.
- i_Step always executes without checking the breakpoint.
- Without the macro: none of these ports exist and run behaviour is as above.

Test Plan:
- Reset, i_Run=1, 4 ALU instructions with i_RegWrite_En=1 -> o_PC_En and o_Reg_We each pulse once every 3 cycles; after 12 active cycles o_Inst_Count=4 and o_Cycle_Count=12.
- Load with MEM_LAT=2 (i_UseMem=1) -> states 1,2,3,3,4; o_Reg_We only in state 4; instruction takes 5 cycles.
- i_Run=0, i_Step pulsed once -> exactly one o_PC_En pulse and return to IDLE. A second i_Step pulse during DECODE -> ignored, o_Inst_Count advances by 1 only.
- i_Halt=1 in EXECUTE -> o_PC_En=0, o_Halted=1, o_Inst_Count+1. i_Run and i_Step held 20 cycles -> no strobes. i_Rst -> state 0, counters 0.
- i_Rst asserted in EXECUTE with i_MemWrite_En=1 -> o_Mem_We=0 that cycle; state=0 next cycle.
- With CNT_W=4, run 20 instructions -> o_Inst_Count stays at 15. With SEQ_BREAKPOINT_EN, i_Break_Addr=3 -> o_Break_Hit pulses at PC=3, core pauses; i_Run toggled 0->1 -> the instruction at 3 executes.
